// File: rtl/down_counter_ld.sv
// Loadable, cascadable synchronous down-counter with terminal count, cascade enable and sticky underflow.
// Optional feature macro: DOWN_COUNTER_LD_AUTORELOAD_EN (underflow reloads di instead of wrapping).
module down_counter_ld #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             ce,
    input  logic             l,
    input  logic [WIDTH-1:0] di,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ceo,
    output logic             uf
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             uf_q;
    logic             uf_d;
    logic             at_zero;

    assign at_zero = (q_q == ZERO);

    // Next-state: load beats count; reset is applied in the register.
    always_comb begin
        q_d  = q_q;
        uf_d = uf_q;
        if (l) begin
            q_d  = di;
            uf_d = 1'b0;
        end else if (ce) begin
            if (!at_zero) begin
                q_d = q_q - WIDTH'(1);
            end else begin
`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
                q_d  = di;
`else
                q_d  = ALL_ONES;
`endif
                uf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            q_q  <= ZERO;
            uf_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            uf_q <= uf_d;
        end
    end

    // tc/ceo stay combinational so a chain resolves within one cycle.
    assign q   = q_q;
    assign uf  = uf_q;
    assign tc  = at_zero;
    assign ceo = ce & at_zero;

endmodule

// File: tb/tb_down_counter_ld.sv
// Directed table-driven bench for down_counter_ld (WIDTH=4) plus a two-stage cascade sequence.
module tb_down_counter_ld;

    typedef struct {
        logic       r;
        logic       l;
        logic       ce;
        logic [3:0] di;
        logic [3:0] eq;
        logic       euf;
    } vec_t;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic       l   = 1'b0;
    logic       ce  = 1'b0;
    logic [3:0] di  = 4'd0;
    logic [3:0] q;
    logic       tc;
    logic       ceo;
    logic       uf;

    logic       c_l     = 1'b0;
    logic       c_ce    = 1'b0;
    logic       c_r     = 1'b0;
    logic [3:0] c_di_lo = 4'd0;
    logic [3:0] c_di_hi = 4'd0;
    logic [3:0] q_lo;
    logic [3:0] q_hi;
    logic       tc_lo;
    logic       tc_hi;
    logic       ceo_lo;
    logic       ceo_hi;
    logic       uf_lo;
    logic       uf_hi;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    down_counter_ld #(.WIDTH(4)) u_dut (
        .clk(clk), .r(r), .ce(ce), .l(l), .di(di),
        .q(q), .tc(tc), .ceo(ceo), .uf(uf)
    );

    down_counter_ld #(.WIDTH(4)) u_lo (
        .clk(clk), .r(c_r), .ce(c_ce), .l(c_l), .di(c_di_lo),
        .q(q_lo), .tc(tc_lo), .ceo(ceo_lo), .uf(uf_lo)
    );

    down_counter_ld #(.WIDTH(4)) u_hi (
        .clk(clk), .r(c_r), .ce(ceo_lo), .l(c_l), .di(c_di_hi),
        .q(q_hi), .tc(tc_hi), .ceo(ceo_hi), .uf(uf_hi)
    );

    function automatic void add(input logic vr, input logic vl, input logic vce,
                                input logic [3:0] vdi, input logic [3:0] veq, input logic veuf);
        vec_t v;
        v.r = vr; v.l = vl; v.ce = vce; v.di = vdi; v.eq = veq; v.euf = veuf;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic etc;
        logic eceo;

        //  r  l  ce  di    q     uf
        add(1, 1, 1, 4'd9, 4'd0,  0);   // reset wins over load and count
        add(0, 1, 0, 4'd3, 4'd3,  0);
        add(0, 0, 1, 4'd3, 4'd2,  0);
        add(0, 0, 1, 4'd3, 4'd1,  0);
        add(0, 0, 1, 4'd3, 4'd0,  0);
`ifndef DOWN_COUNTER_LD_AUTORELOAD_EN
        add(0, 0, 1, 4'd3, 4'd15, 1);   // wrap through zero
        add(0, 0, 1, 4'd3, 4'd14, 1);
`endif
        add(0, 1, 0, 4'd5, 4'd5,  0);
        add(0, 0, 0, 4'd9, 4'd5,  0);   // di ignored while not loading
        add(0, 0, 0, 4'd9, 4'd5,  0);
        add(0, 0, 0, 4'd9, 4'd5,  0);
        add(0, 1, 1, 4'd12, 4'd12, 0);  // load beats count
        add(0, 1, 0, 4'd0, 4'd0,  0);
`ifndef DOWN_COUNTER_LD_AUTORELOAD_EN
        add(0, 0, 1, 4'd0, 4'd15, 1);
        for (int k = 14; k >= 7; k--) add(0, 0, 1, 4'd0, 4'(k), 1);
        add(1, 0, 1, 4'd0, 4'd0,  0);   // reset mid-count
        add(0, 0, 1, 4'd0, 4'd15, 1);
        add(0, 0, 0, 4'd0, 4'd15, 1);
        add(1, 1, 1, 4'd9, 4'd0,  0);
`else
        add(0, 0, 1, 4'd0, 4'd0,  1);   // di=0 reload: stays at zero
        add(0, 0, 1, 4'd0, 4'd0,  1);
        add(0, 1, 0, 4'd2, 4'd2,  0);
        add(0, 0, 1, 4'd2, 4'd1,  0);
        add(0, 0, 1, 4'd2, 4'd0,  0);
        add(0, 0, 1, 4'd2, 4'd2,  1);
        add(0, 0, 1, 4'd2, 4'd1,  1);
        add(0, 0, 1, 4'd2, 4'd0,  1);
        add(0, 0, 1, 4'd2, 4'd2,  1);
        add(0, 0, 0, 4'd2, 4'd2,  1);
        add(1, 0, 1, 4'd2, 4'd0,  0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            r  = vecs[i].r;
            l  = vecs[i].l;
            ce = vecs[i].ce;
            di = vecs[i].di;
            @(posedge clk);
            #1;
            etc  = (vecs[i].eq == 4'd0);
            eceo = vecs[i].ce & etc;
            check("q",   i, 32'(q),   32'(vecs[i].eq));
            check("tc",  i, 32'(tc),  32'(etc));
            check("ceo", i, 32'(ceo), 32'(eceo));
            check("uf",  i, 32'(uf),  32'(vecs[i].euf));
        end

`ifndef DOWN_COUNTER_LD_AUTORELOAD_EN
        // Two-stage cascade loaded with 0x10 and then counted down.
        @(negedge clk);
        c_r = 1'b1;
        @(negedge clk);
        c_r = 1'b0; c_l = 1'b1; c_di_lo = 4'h0; c_di_hi = 4'h1;
        @(posedge clk); #1;
        check("casc_load", 0, 32'({q_hi, q_lo}), 32'h10);
        check("casc_lo_tc", 0, 32'(tc_lo), 32'd1);
        @(negedge clk);
        c_l = 1'b0; c_ce = 1'b1;
        #1;
        check("casc_ceo_lo", 0, 32'(ceo_lo), 32'd1);
        @(posedge clk); #1;
        check("casc_dec1", 1, 32'({q_hi, q_lo}), 32'h0F);
        check("casc_ceo_lo", 1, 32'(ceo_lo), 32'd0);
        @(posedge clk); #1;
        check("casc_dec2", 2, 32'({q_hi, q_lo}), 32'h0E);
        check("casc_tc_all", 2, 32'(tc_lo & tc_hi), 32'd0);
        @(negedge clk);
        c_ce = 1'b0;
`else
        // Period-3 divider: ceo pulses once every third enabled cycle.
        @(negedge clk);
        c_r = 1'b0; c_l = 1'b1; c_di_lo = 4'd2; c_di_hi = 4'd0;
        @(posedge clk); #1;
        check("div_load", 0, 32'(q_lo), 32'd2);
        @(negedge clk);
        c_l = 1'b0; c_ce = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check("div_ceo", k, 32'(ceo_lo), 32'((k % 3) == 2));
        end
        @(negedge clk);
        c_ce = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
